display_scan_controller: RTL and testbench

Sequences the calculator's 7-segment display output circuit. It time-multiplexes the four digit positions by driving the 4:1 digit select and the active-low anode enables. A mode FSM chooses between showing the user operand and showing the ALU result, driving the 2:1 source select. It also holds the ALU result and sign in registers, so the displayed value stays stable while the ALU inputs change.

---
 rtl/display_ctrl_pkg.sv | 32 +++
 rtl/display_scan_controller_if.sv | 35 +++
 rtl/digit_scan_counter.sv | 55 +++++
 rtl/display_scan_controller.sv | 105 ++++++++++
 tb/tb_display_scan_controller.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/display_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// display_ctrl_pkg
// Shared types and constants for the calculator display scan controller.
//   state_t     : display mode FSM encoding (ENTRY / WAIT / RESULT / ERR)
//   AN_ALL_OFF  : anode pattern with every digit dark (active-low enables)
//   DIGITS      : number of multiplexed digit positions
//   IDX_W       : width of the scan index
// -----------------------------------------------------------------------------
package display_ctrl_pkg;

    typedef enum logic [1:0] {
        ENTRY  = 2'b00,
        WAIT   = 2'b01,
        RESULT = 2'b10,
        ERR    = 2'b11
    } state_t;

    localparam logic [7:0] AN_ALL_OFF = 8'hFF;
    localparam int         DIGITS     = 4;
    localparam int         IDX_W      = 2;

    // Digits are dark while a result is pending or after a timeout.
    function automatic logic blank_for(input state_t s);
        return (s == WAIT) || (s == ERR);
    endfunction

    // Display source is the held ALU result in RESULT and ERR.
    function automatic logic shows_result(input state_t s);
        return (s == RESULT) || (s == ERR);
    endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// -----------------------------------------------------------------------------
// display_scan_controller_if
// Groups the controller's event inputs, ALU result inputs and display outputs.
//   slave  : view used by display_scan_controller (events in, display out)
//   master : view used by whatever drives the events and observes the display
// -----------------------------------------------------------------------------
interface display_scan_controller_if;

    logic        clear;
    logic        user_key_strobe;
    logic        calc_req;
    logic        alu_valid;
    logic [11:0] alu_result;
    logic        alu_sign;
    logic [1:0]  four_to_one_sel;
    logic        two_to_one_sel;
    logic [7:0]  an_n;
    logic [11:0] alu_result_q;
    logic        alu_sign_q;
    logic        busy;
    logic        timeout_err;

    modport slave (
        input  clear, user_key_strobe, calc_req, alu_valid, alu_result, alu_sign,
        output four_to_one_sel, two_to_one_sel, an_n, alu_result_q, alu_sign_q,
               busy, timeout_err
    );

    modport master (
        output clear, user_key_strobe, calc_req, alu_valid, alu_result, alu_sign,
        input  four_to_one_sel, two_to_one_sel, an_n, alu_result_q, alu_sign_q,
               busy, timeout_err
    );

endinterface

// File: rtl/digit_scan_counter.sv
// -----------------------------------------------------------------------------
// digit_scan_counter
// Refresh prescaler, digit scan index and active-low anode decode.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   blank : force all anodes off (digits dark)
//   idx   : current digit position, advances once per REFRESH_DIV cycles
//   an_n  : active-low anode enables; upper four bits always 1
// The scan keeps running while blanked so the refresh phase is undisturbed.
// -----------------------------------------------------------------------------
module digit_scan_counter
    import display_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             blank,
    output logic [IDX_W-1:0] idx,
    output logic [7:0]       an_n
);

    logic [CNT_W-1:0]  r_presc;
    logic [IDX_W-1:0]  r_idx;
    logic              w_slot_end;
    logic [DIGITS-1:0] w_an_low;

    assign w_slot_end = (r_presc == CNT_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_slot_end) begin
            r_presc <= '0;
            // Two-bit index wraps 3 -> 0 on its own.
            r_idx   <= r_idx + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // One enable per digit, pulled low only for the selected position.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_anode
            assign w_an_low[gi] = (r_idx != IDX_W'(gi));
        end
    endgenerate

    assign idx  = r_idx;
    assign an_n = blank ? AN_ALL_OFF : {{(8 - DIGITS){1'b1}}, w_an_low};

endmodule

// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
// Sequences the calculator's 7-segment output: digit scan, source select and
// a hold register for the ALU result so the display is stable while the ALU
// inputs move.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave view of display_scan_controller_if
//           in  : clear, user_key_strobe, calc_req, alu_valid, alu_result, alu_sign
//           out : four_to_one_sel, two_to_one_sel, an_n, alu_result_q,
//                 alu_sign_q, busy, timeout_err
// Event priority in one cycle: clear > alu_valid > timeout > calc_req > key.
// -----------------------------------------------------------------------------
module display_scan_controller
    import display_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int CNT_W       = 20
) (
    input  logic                        clk,
    input  logic                        rst_n,
    display_scan_controller_if.slave    bus
);

    state_t           r_state;
    logic [CNT_W-1:0] r_tcnt;
    logic [11:0]      r_alu_result;
    logic             r_alu_sign;

    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_an_n;
    logic             w_timeout;

    assign w_timeout = (r_tcnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ENTRY;
            r_tcnt       <= '0;
            r_alu_result <= '0;
            r_alu_sign   <= 1'b0;
        end else if (bus.clear) begin
            r_state      <= ENTRY;
            r_tcnt       <= '0;
            r_alu_result <= '0;
            r_alu_sign   <= 1'b0;
        end else begin
            unique case (r_state)
                ENTRY: begin
                    if (bus.calc_req) begin
                        r_state <= WAIT;
                        r_tcnt  <= '0;
                    end
                end
                WAIT: begin
                    // A result arriving on the last allowed cycle still wins.
                    if (bus.alu_valid) begin
                        r_alu_result <= bus.alu_result;
                        r_alu_sign   <= bus.alu_sign;
                        r_state      <= RESULT;
                    end else if (w_timeout) begin
                        r_state <= ERR;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                RESULT: begin
                    if (bus.calc_req) begin
                        r_state <= WAIT;
                        r_tcnt  <= '0;
                    end else if (bus.user_key_strobe) begin
                        r_state <= ENTRY;
                    end
                end
                ERR: begin
                    if (bus.calc_req || bus.user_key_strobe) begin
                        r_state <= ENTRY;
                    end
                end
                default: r_state <= ENTRY;
            endcase
        end
    end

    digit_scan_counter #(
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W)
    ) u_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .blank (blank_for(r_state)),
        .idx   (w_idx),
        .an_n  (w_an_n)
    );

    assign bus.four_to_one_sel = w_idx;
    assign bus.two_to_one_sel  = shows_result(r_state);
    assign bus.an_n            = w_an_n;
    assign bus.alu_result_q    = r_alu_result;
    assign bus.alu_sign_q      = r_alu_sign;
    assign bus.busy            = (r_state == WAIT);
    assign bus.timeout_err     = (r_state == ERR);

endmodule

// File: tb/tb_display_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_display_scan_controller
// Directed scenarios followed by random event pulses, every cycle compared
// against a behavioural model of the display controller.
// -----------------------------------------------------------------------------
module tb_display_scan_controller;

    localparam int RD = 4;
    localparam int TO = 16;

    localparam int M_ENTRY  = 0;
    localparam int M_WAIT   = 1;
    localparam int M_RESULT = 2;
    localparam int M_ERR    = 3;

    logic clk;
    logic rst_n;

    display_scan_controller_if bus();

    display_scan_controller #(
        .REFRESH_DIV (RD),
        .TIMEOUT_CYC (TO),
        .CNT_W       (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int n_cyc  = 0;

    // Reference model state
    int          m_mode;
    int          m_edges;    // clock edges seen since reset released
    int          m_waited;   // WAIT cycles spent without a result
    logic [11:0] m_res;
    logic        m_sign;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n_cyc);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_ENTRY;
        m_edges  = 0;
        m_waited = 0;
        m_res    = '0;
        m_sign   = 1'b0;
    endtask

    task automatic model_step(input logic c, input logic k, input logic q, input logic v,
                              input logic [11:0] r, input logic s);
        m_edges++;
        if (c) begin
            m_mode = M_ENTRY;
            m_res  = '0;
            m_sign = 1'b0;
        end else begin
            case (m_mode)
                M_ENTRY:  if (q) begin m_mode = M_WAIT; m_waited = 0; end
                M_WAIT: begin
                    if (v) begin
                        m_res  = r;
                        m_sign = s;
                        m_mode = M_RESULT;
                    end else begin
                        m_waited++;
                        if (m_waited == TO) m_mode = M_ERR;
                    end
                end
                M_RESULT: begin
                    if (q) begin m_mode = M_WAIT; m_waited = 0; end
                    else if (k) m_mode = M_ENTRY;
                end
                default:  if (q || k) m_mode = M_ENTRY;
            endcase
        end
    endtask

    task automatic check_outputs();
        int   e_idx;
        logic e_dark;
        logic [7:0] e_an;
        e_idx  = (m_edges / RD) % 4;
        e_dark = (m_mode == M_WAIT) || (m_mode == M_ERR);
        e_an   = e_dark ? 8'hFF : (8'hFF ^ (8'h01 << e_idx));
        check("sel4",    32'(bus.four_to_one_sel), 32'(e_idx));
        check("an_n",    32'(bus.an_n), 32'(e_an));
        check("sel2",    32'(bus.two_to_one_sel), 32'((m_mode == M_RESULT) || (m_mode == M_ERR)));
        check("busy",    32'(bus.busy), 32'(m_mode == M_WAIT));
        check("tmo",     32'(bus.timeout_err), 32'(m_mode == M_ERR));
        check("res_q",   32'(bus.alu_result_q), 32'(m_res));
        check("sign_q",  32'(bus.alu_sign_q), 32'(m_sign));
    endtask

    // One clock: apply pulses, let the edge happen, compare on the falling edge.
    task automatic cycle(input logic c, input logic k, input logic q, input logic v,
                         input logic [11:0] r, input logic s);
        bus.clear           = c;
        bus.user_key_strobe = k;
        bus.calc_req        = q;
        bus.alu_valid       = v;
        bus.alu_result      = r;
        bus.alu_sign        = s;
        @(posedge clk);
        if (rst_n) model_step(c, k, q, v, r, s);
        else       model_reset();
        @(negedge clk);
        n_cyc++;
        check_outputs();
        $display("cyc %0d clr=%0b key=%0b calc=%0b val=%0b res=%03h | sel=%0d an=%02h src=%0b busy=%0b err=%0b q=%03h/%0b",
                 n_cyc, c, k, q, v, r, bus.four_to_one_sel, bus.an_n, bus.two_to_one_sel,
                 bus.busy, bus.timeout_err, bus.alu_result_q, bus.alu_sign_q);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.clear           = 1'b0;
        bus.user_key_strobe = 1'b0;
        bus.calc_req        = 1'b0;
        bus.alu_valid       = 1'b0;
        bus.alu_result      = '0;
        bus.alu_sign        = 1'b0;

        // Reset values
        @(negedge clk);
        model_reset();
        check_outputs();
        rst_n = 1'b1;

        // Free-running scan in ENTRY
        idle(32);

        // Request, result after five busy cycles
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
        idle(4);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 12'h0F3, 1'b1);
        idle(8);

        // Key press leaves RESULT, held value stays
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
        idle(3);

        // Timeout to ERR, late result ignored, key returns to ENTRY
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
        idle(18);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 12'hABC, 1'b0);
        idle(2);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
        idle(2);

        // Result on the final allowed WAIT cycle wins over timeout
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
        idle(TO - 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 12'h555, 1'b0);
        idle(2);

        // clear beats alu_valid in WAIT
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
        idle(3);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 12'h777, 1'b1);
        idle(2);

        // Asynchronous reset in the middle of WAIT, between clock edges
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 12'h3C1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
        idle(5);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 12'h123, 1'b1);
        idle(4);

        // Random event pulses
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(39) == 0),
                  ($urandom_range(7) == 0),
                  ($urandom_range(7) == 0),
                  ($urandom_range(5) == 0),
                  12'($urandom),
                  1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
